// File: rtl/cva6_trace_collector.sv
// Serialises the CVA6 per-commit-port trace into timestamped records on a valid/ready stream.
// Buffers commit bursts in a small FIFO; lanes that do not fit are dropped and counted.
module cva6_trace_collector #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int LANE_W          = 128,
    parameter int DEPTH           = 8,
    parameter int STAMP_W         = 32,
    parameter int DROP_W          = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NR_COMMIT_PORTS*LANE_W-1:0] trace_i,
    input  logic                              enable_i,
    input  logic                              clear_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [STAMP_W+LANE_W-1:0]         out_data_o,
    output logic [$clog2(DEPTH):0]            fill_o,
    output logic [DROP_W-1:0]                 drop_cnt_o,
    output logic                              overflow_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int CNT_W  = (FILL_W > 3) ? FILL_W : 3;
    localparam int REC_W  = STAMP_W + LANE_W;
    localparam int DSUM_W = DROP_W + 1;

    logic [REC_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FILL_W-1:0]  r_fill;
    logic [STAMP_W-1:0] r_stamp;
    logic [DROP_W-1:0]  r_drop;
    logic               r_ovf;
    logic               r_valid;
    logic [REC_W-1:0]   r_head;

    logic [CNT_W-1:0]           w_free;
    logic [CNT_W-1:0]           w_live_cnt;
    logic [CNT_W-1:0]           w_push_cnt;
    logic [CNT_W-1:0]           w_drop_cnt;
    logic [NR_COMMIT_PORTS-1:0] w_we;
    logic [PTR_W-1:0]           w_waddr [NR_COMMIT_PORTS];
    logic [REC_W-1:0]           w_first_rec;
    logic                       w_pop;
    logic [FILL_W-1:0]          w_fill_nxt;
    logic [PTR_W-1:0]           w_rd_nxt;
    logic [PTR_W-1:0]           w_wr_nxt;
    logic [REC_W-1:0]           w_head_nxt;
    logic [DSUM_W-1:0]          w_drop_sum;

    // Live lanes take consecutive slots from the write pointer until free space runs out.
    always_comb begin
        w_free      = CNT_W'(DEPTH) - CNT_W'(r_fill);
        w_live_cnt  = '0;
        w_push_cnt  = '0;
        w_we        = '0;
        w_waddr     = '{default: '0};
        w_first_rec = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (enable_i && trace_i[k*LANE_W+2] && trace_i[k*LANE_W+1]) begin
                if (w_live_cnt < w_free) begin
                    w_we[k]    = 1'b1;
                    w_waddr[k] = r_wr_ptr + PTR_W'(w_live_cnt);
                    if (w_live_cnt == '0) begin
                        w_first_rec = {r_stamp, trace_i[k*LANE_W +: LANE_W]};
                    end
                    w_push_cnt = w_push_cnt + 1'b1;
                end
                w_live_cnt = w_live_cnt + 1'b1;
            end
        end
        w_drop_cnt = w_live_cnt - w_push_cnt;

        w_pop      = r_valid & out_ready_i;
        w_fill_nxt = r_fill + FILL_W'(w_push_cnt) - FILL_W'(w_pop);
        w_rd_nxt   = r_rd_ptr + PTR_W'(w_pop);
        w_wr_nxt   = r_wr_ptr + PTR_W'(w_push_cnt);

        // When the surviving FIFO is empty, the new head is the record being written now.
        if (w_fill_nxt == '0) begin
            w_head_nxt = '0;
        end else if ((r_fill - FILL_W'(w_pop)) == '0) begin
            w_head_nxt = w_first_rec;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end

        w_drop_sum = {1'b0, r_drop} + DSUM_W'(w_drop_cnt);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
                if (w_we[k]) begin
                    r_mem[w_waddr[k]] <= {r_stamp, trace_i[k*LANE_W +: LANE_W]};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_stamp  <= '0;
            r_drop   <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            r_stamp  <= r_stamp + 1'b1;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_fill   <= w_fill_nxt;
            r_valid  <= (w_fill_nxt != '0);
            r_head   <= w_head_nxt;
            if (clear_i) begin
                r_drop <= '0;
                r_ovf  <= 1'b0;
            end else if (w_drop_cnt != '0) begin
                r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
                r_ovf  <= 1'b1;
            end
        end
    end

    assign out_valid_o = r_valid;
    assign out_data_o  = r_head;
    assign fill_o      = r_fill;
    assign drop_cnt_o  = r_drop;
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_cva6_trace_collector.sv
// Directed bench for cva6_trace_collector: a queue-based reference model checked every cycle,
// plus literal expectations on key cycles.
module tb_cva6_trace_collector;

    localparam int NR = 2;
    localparam int LW = 128;
    localparam int D  = 8;
    localparam int SW = 32;
    localparam int DW = 16;
    localparam int RW = SW + LW;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*LW-1:0] trace;
    logic             en;
    logic             clr;
    logic             rdy;
    logic             out_valid;
    logic [RW-1:0]    out_data;
    logic [3:0]       fill;
    logic [DW-1:0]    drop_cnt;
    logic             ovf;

    always #5 clk = ~clk;

    cva6_trace_collector #(
        .NR_COMMIT_PORTS(NR), .LANE_W(LW), .DEPTH(D), .STAMP_W(SW), .DROP_W(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .trace_i(trace), .enable_i(en), .clear_i(clr),
        .out_valid_o(out_valid), .out_ready_i(rdy), .out_data_o(out_data),
        .fill_o(fill), .drop_cnt_o(drop_cnt), .overflow_o(ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [RW-1:0] q[$];
    logic [SW-1:0] m_stamp = '0;
    int            m_drop  = 0;
    bit            m_ovf   = 1'b0;

    function automatic logic [LW-1:0] mk_lane(bit v, bit nr, logic [39:0] iaddr, logic [31:0] insn);
        logic [LW-1:0] l;
        l         = '0;
        l[0]      = 1'b1;
        l[1]      = nr;
        l[2]      = v;
        l[42:3]   = iaddr;
        l[74:43]  = insn;
        l[77:75]  = 3'd3;
        l[87:80]  = 8'h5a;
        l[127:88] = {8'h00, insn};
        return l;
    endfunction

    task automatic check(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update();
        logic [RW-1:0] nw[$];
        logic [LW-1:0] lane;
        int free;
        int ndrop;
        if (rst) begin
            q.delete();
            m_stamp = '0;
            m_drop  = 0;
            m_ovf   = 1'b0;
        end else begin
            free  = D - q.size();
            ndrop = 0;
            for (int k = 0; k < NR; k++) begin
                lane = trace[k*LW +: LW];
                if (en && lane[2] && lane[1]) begin
                    if (free > 0) begin
                        nw.push_back({m_stamp, lane});
                        free--;
                    end else begin
                        ndrop++;
                    end
                end
            end
            if (q.size() != 0 && rdy) void'(q.pop_front());
            foreach (nw[i]) q.push_back(nw[i]);
            if (clr) begin
                m_drop = 0;
                m_ovf  = 1'b0;
            end else if (ndrop > 0) begin
                m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
                m_ovf  = 1'b1;
            end
            m_stamp = m_stamp + 1'b1;
        end
    endtask

    task automatic step();
        logic [RW-1:0] exp_data;
        model_update();
        @(posedge clk);
        #1;
        exp_data = (q.size() != 0) ? q[0] : '0;
        check("valid", RW'(out_valid), RW'(q.size() != 0));
        check("data", out_data, exp_data);
        check("fill", RW'(fill), RW'(q.size()));
        check("drop_cnt", RW'(drop_cnt), RW'(m_drop));
        check("overflow", RW'(ovf), RW'(m_ovf));
    endtask

    logic [SW-1:0] pushed_stamp;

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; rdy = 1'b1;
        trace = {mk_lane(1, 1, 40'h10, 32'h1), mk_lane(1, 1, 40'h20, 32'h2)};

        // reset with all lanes live
        repeat (3) step();
        check("rst_valid", RW'(out_valid), '0);
        check("rst_fill", RW'(fill), '0);
        check("rst_data", out_data, '0);

        rst = 1'b0;
        trace = {mk_lane(0, 1, 40'h0, 32'h0), mk_lane(1, 1, 40'h44, 32'h55)};
        step();
        check("first_stamp", RW'(out_data[RW-1:LW]), RW'(0));
        check("first_valid", RW'(out_valid), RW'(1));
        trace = '0;
        step();

        // single lane at stamp 5
        rst = 1'b1; step();
        rst = 1'b0;
        repeat (5) step();
        trace = {mk_lane(0, 0, 40'h0, 32'h0), mk_lane(1, 1, 40'h80000000, 32'h13)};
        step();
        check("t2_stamp", RW'(out_data[RW-1:LW]), RW'(5));
        check("t2_iaddr", RW'(out_data[42:3]), RW'(40'h80000000));
        trace = '0;
        step();
        check("t2_valid_drop", RW'(out_valid), RW'(0));

        // dual commit with sink stalled
        rdy = 1'b0;
        trace = {mk_lane(1, 1, 40'h104, 32'h93), mk_lane(1, 1, 40'h100, 32'h13)};
        pushed_stamp = m_stamp;
        step();
        trace = '0;
        check("t3_fill", RW'(fill), RW'(2));
        check("t3_head", RW'(out_data[74:43]), RW'(32'h13));
        step();
        check("t3_hold", RW'(out_data[74:43]), RW'(32'h13));
        rdy = 1'b1;
        step();
        check("t3_second", RW'(out_data[74:43]), RW'(32'h93));
        check("t3_stamp", RW'(out_data[RW-1:LW]), RW'(pushed_stamp));
        step();

        // overflow then clear
        rdy = 1'b0;
        trace = {mk_lane(1, 1, 40'h200, 32'h3), mk_lane(1, 1, 40'h1fc, 32'h4)};
        repeat (5) step();
        trace = '0;
        check("t4_fill", RW'(fill), RW'(8));
        check("t4_drop", RW'(drop_cnt), RW'(2));
        check("t4_ovf", RW'(ovf), RW'(1));
        clr = 1'b1; step(); clr = 1'b0;
        check("t4_clr_drop", RW'(drop_cnt), RW'(0));
        check("t4_clr_ovf", RW'(ovf), RW'(0));
        check("t4_clr_fill", RW'(fill), RW'(8));

        // full FIFO: push+pop with clear beating the drop
        rdy = 1'b1; clr = 1'b1;
        trace = {mk_lane(1, 1, 40'h300, 32'h5), mk_lane(1, 1, 40'h2fc, 32'h6)};
        step();
        clr = 1'b0;
        check("t6_fill", RW'(fill), RW'(7));
        check("t6_drop", RW'(drop_cnt), RW'(0));
        check("t6_ovf", RW'(ovf), RW'(0));
        step();
        check("t6b_fill", RW'(fill), RW'(7));
        check("t6b_drop", RW'(drop_cnt), RW'(1));
        trace = '0;
        repeat (10) step();

        // qualification
        clr = 1'b1; step(); clr = 1'b0;
        trace = {mk_lane(1, 0, 40'h400, 32'h7), mk_lane(1, 0, 40'h3fc, 32'h8)};
        step();
        check("t5_nrst_fill", RW'(fill), RW'(0));
        en = 1'b0;
        trace = {mk_lane(1, 1, 40'h500, 32'h9), mk_lane(1, 1, 40'h4fc, 32'ha)};
        step();
        check("t5_en_fill", RW'(fill), RW'(0));
        check("t5_en_drop", RW'(drop_cnt), RW'(0));
        en = 1'b1;

        // mixed burst with stalls and a mid-burst reset
        for (int i = 0; i < 40; i++) begin
            trace = {mk_lane(i % 4 == 0, 1, 40'(i * 8 + 4), 32'(i + 100)),
                     mk_lane(i % 3 != 2, 1, 40'(i * 8), 32'(i + 200))};
            rdy = (i % 5 != 1) && (i < 12 || i > 18);
            rst = (i == 25);
            step();
        end
        rst = 1'b0; trace = '0; rdy = 1'b1;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
